// File: rtl/restoring_div8by4_pkg.sv
// restoring_div8by4_pkg: shared widths, state encoding and constants for the divider
package restoring_div8by4_pkg;
    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int CNT_W      = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 8'hFF;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/restoring_div8by4_div_step.sv
// div_step: one combinational restoring-division iteration (shift in a bit, conditionally subtract)
//   r_i      : current partial remainder (DIVISOR_W+1 bits)
//   bit_i    : next dividend bit shifted into the remainder
//   d_i      : divisor
//   r_next_o : partial remainder after the iteration
//   q_bit_o  : quotient bit produced by the iteration
module div_step
    import restoring_div8by4_pkg::*;
(
    input  logic [DIVISOR_W:0]   r_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] d_i,
    output logic [DIVISOR_W:0]   r_next_o,
    output logic                 q_bit_o
);
    logic [DIVISOR_W:0] t;
    assign t = {r_i[DIVISOR_W-1:0], bit_i};
    // A set top bit in r_i means the shifted value already exceeds any divisor.
    assign q_bit_o  = r_i[DIVISOR_W] | (t >= {1'b0, d_i});
    assign r_next_o = q_bit_o ? t - {1'b0, d_i} : t;
endmodule

// File: rtl/restoring_div8by4.sv
// restoring_div8by4: sequential unsigned 8/4 restoring divider with start/busy/done handshake
//   clk, rst   : clock and synchronous active-high reset
//   start      : request, sampled in IDLE and DONE
//   dividend   : numerator, captured on an accepted start
//   divisor    : denominator, captured on an accepted start
//   busy       : high while iterating
//   done       : one-cycle pulse when the result registers update
//   quotient   : registered quotient (8'hFF on divide by zero)
//   remainder  : registered remainder
//   dbz        : divide-by-zero flag belonging to the current result
module restoring_div8by4
    import restoring_div8by4_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dbz
);
    state_t                state_q;
    logic [DIVIDEND_W-1:0] q_q;
    logic [DIVISOR_W-1:0]  d_q;
    logic [DIVISOR_W:0]    r_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  dbz_q;
    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W:0]    r_d;
    logic                  q_bit_d;
    logic [DIVIDEND_W-1:0] q_d;

    div_step u_step (
        .r_i      (r_q),
        .bit_i    (q_q[DIVIDEND_W-1]),
        .d_i      (d_q),
        .r_next_o (r_d),
        .q_bit_o  (q_bit_d)
    );

    // The dividend shifts out of the top while quotient bits shift in at the bottom.
    assign q_d = {q_q[DIVIDEND_W-2:0], q_bit_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start && divisor != '0) begin
                        q_q     <= dividend;
                        d_q     <= divisor;
                        r_q     <= '0;
                        cnt_q   <= CNT_W'(DIVIDEND_W - 1);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else if (start) begin
                        quot_q  <= DBZ_QUOTIENT;
                        rem_q   <= '0;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        quot_q  <= q_d;
                        rem_q   <= r_d[DIVISOR_W-1:0];
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;
endmodule
